// File: rtl/stream_mux_pkg.sv
// stream_mux_pkg: round-robin pick helper and reset constant for the stream_mux_rr pointer
package stream_mux_pkg;
  localparam int RR_MAX_N = 64;
  typedef struct packed {
    logic       found;
    logic [5:0] idx;
  } rr_pick_t;
  function automatic int rr_ptr_rst(input int n);
    return n - 1;
  endfunction
  // Scan ptr+1 .. ptr+n modulo n, so the last winner gets the lowest priority.
  function automatic rr_pick_t rr_next(input int ptr, input logic [RR_MAX_N-1:0] valid, input int n);
    rr_pick_t r;
    int c;
    r = '0;
    for (int k = 1; k <= RR_MAX_N; k++) begin
      if (k <= n) begin
        c = ptr + k;
        if (c >= n) c = c - n;
        if (!r.found && valid[c]) begin
          r.found = 1'b1;
          r.idx = 6'(c);
        end
      end
    end
    return r;
  endfunction
endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// rr_arbiter: combinational rotate-priority pick starting after ptr
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter int N = 4,
  localparam int SW = $clog2(N)
) (
  input  logic [SW-1:0] ptr,
  input  logic [N-1:0]  valid,
  output logic [SW-1:0] grant,
  output logic          found
);
  logic [RR_MAX_N-1:0] v;
  rr_pick_t p;
  always_comb begin
    v = '0;
    v[N-1:0] = valid;
    p = rr_next(int'(ptr), v, N);
  end
  assign grant = SW'(p.idx);
  assign found = p.found;
endmodule

// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N-channel valid/ready mux with fixed or round-robin select; STREAM_MUX_LOCK_EN adds packet lock
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 8,
  localparam int SW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N*W-1:0] in_data,
  input  logic [N-1:0]   in_valid,
  output logic [N-1:0]   in_ready,
`ifdef STREAM_MUX_LOCK_EN
  input  logic [N-1:0]   in_last,
  output logic           out_last,
`endif
  input  logic           mode,
  input  logic [SW-1:0]  sel,
  output logic [W-1:0]   out_data,
  output logic [SW-1:0]  out_ch,
  output logic           out_valid,
  input  logic           out_ready
);
  localparam logic [SW:0] NN = (SW+1)'(N);
  logic [SW-1:0] ptr, rr_grant, grant;
  logic rr_found, fixed_ok, found, load_en, xfer;
  rr_arbiter #(.N(N)) u_arb (.ptr(ptr), .valid(in_valid), .grant(rr_grant), .found(rr_found));
  assign load_en  = !out_valid || out_ready;
  assign fixed_ok = ({1'b0, sel} < NN) && in_valid[sel];
`ifdef STREAM_MUX_LOCK_EN
  logic locked;
  logic [SW-1:0] lock_ch;
  assign grant = locked ? lock_ch : mode ? rr_grant : sel;
  assign found = locked ? in_valid[lock_ch] : mode ? rr_found : fixed_ok;
  always_ff @(posedge clk) begin
    if (rst) begin
      locked   <= 1'b0;
      lock_ch  <= '0;
      out_last <= 1'b0;
    end else if (xfer) begin
      locked   <= !in_last[grant];
      lock_ch  <= grant;
      out_last <= in_last[grant];
    end
  end
`else
  assign grant = mode ? rr_grant : sel;
  assign found = mode ? rr_found : fixed_ok;
`endif
  // Grant never looks at in_ready; only load_en couples out_ready to in_ready.
  assign xfer     = found && load_en && !rst;
  assign in_ready = xfer ? N'(1) << grant : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      ptr       <= SW'(rr_ptr_rst(N));
    end else if (load_en) begin
      out_valid <= xfer;
      if (xfer) begin
        out_data <= in_data[grant*W +: W];
        out_ch   <= grant;
        ptr      <= grant;
      end
    end
  end
endmodule

// File: tb/tb_stream_mux_rr.sv
// tb_stream_mux_rr: directed self-checking bench for stream_mux_rr (N=4 and N=3 instances)
module tb_stream_mux_rr;
  logic clk = 0, rst = 1;
  logic [31:0] in_data = '0;
  logic [3:0] in_valid = '0, in_ready;
  logic mode = 0, out_valid, out_ready = 1;
  logic [1:0] sel = '0, out_ch;
  logic [7:0] out_data;
  logic [23:0] d3 = 24'h332211;
  logic [2:0] v3 = '0, r3;
  logic m3 = 0, ov3;
  logic [1:0] s3 = '0, oc3;
  logic [7:0] od3;
  int checks = 0, errors = 0;
`ifdef STREAM_MUX_LOCK_EN
  logic [3:0] in_last = '0;
  logic [2:0] l3 = '0;
  logic out_last, ol3;
`endif
  always #5 clk = ~clk;
  stream_mux_rr #(.N(4), .W(8)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
`ifdef STREAM_MUX_LOCK_EN
    .in_last(in_last), .out_last(out_last),
`endif
    .mode(mode), .sel(sel), .out_data(out_data), .out_ch(out_ch),
    .out_valid(out_valid), .out_ready(out_ready));
  stream_mux_rr #(.N(3), .W(8)) dut3 (
    .clk(clk), .rst(rst), .in_data(d3), .in_valid(v3), .in_ready(r3),
`ifdef STREAM_MUX_LOCK_EN
    .in_last(l3), .out_last(ol3),
`endif
    .mode(m3), .sel(s3), .out_data(od3), .out_ch(oc3),
    .out_valid(ov3), .out_ready(1'b1));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1; in_valid = 4'b1111; mode = 1;
    in_data = 32'h13121110;
    #1;
    checks++;
    if (in_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got %b exp 0000", in_ready); end
    tick; tick;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || out_ch !== 2'd0) begin
      errors++; $display("FAIL reset_out got v=%b d=%h ch=%0d exp v=0 d=00 ch=0", out_valid, out_data, out_ch);
    end
    rst = 0; in_valid = 4'b0000;
  endtask

  task automatic test_rr_priority;
    logic [1:0] exp_g [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    mode = 1; in_valid = 4'b1111; out_ready = 1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (in_ready !== (4'b0001 << exp_g[i])) begin
        errors++; $display("FAIL rr_ready[%0d] got %b exp %b", i, in_ready, 4'b0001 << exp_g[i]);
      end
      tick;
      checks++;
      if (out_valid !== 1'b1 || out_ch !== exp_g[i] || out_data !== 8'h10 + 8'(exp_g[i])) begin
        errors++; $display("FAIL rr_out[%0d] got v=%b ch=%0d d=%h exp v=1 ch=%0d d=%h",
                           i, out_valid, out_ch, out_data, exp_g[i], 8'h10 + 8'(exp_g[i]));
      end
    end
  endtask

  task automatic test_fixed;
    mode = 0; sel = 2; in_valid = 4'b0100; in_data[23:16] = 8'hA5;
    #1;
    checks++;
    if (in_ready !== 4'b0100) begin errors++; $display("FAIL fixed_ready got %b exp 0100", in_ready); end
    tick;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_ch !== 2'd2) begin
      errors++; $display("FAIL fixed_out got v=%b d=%h ch=%0d exp v=1 d=a5 ch=2", out_valid, out_data, out_ch);
    end
    in_valid = 4'b1011;
    #1;
    checks++;
    if (in_ready !== 4'b0000) begin errors++; $display("FAIL fixed_novalid_ready got %b exp 0000", in_ready); end
    tick;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL fixed_drain got v=%b exp 0", out_valid); end
  endtask

  task automatic test_backpressure;
    mode = 0; sel = 1; in_valid = 4'b0010; in_data[15:8] = 8'h11; out_ready = 1;
    tick;
    out_ready = 0; in_data[15:8] = 8'h22;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (in_ready !== 4'b0000) begin errors++; $display("FAIL bp_ready[%0d] got %b exp 0000", i, in_ready); end
      tick;
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'h11 || out_ch !== 2'd1) begin
        errors++; $display("FAIL bp_hold[%0d] got v=%b d=%h ch=%0d exp v=1 d=11 ch=1", i, out_valid, out_data, out_ch);
      end
    end
    out_ready = 1;
    #1;
    checks++;
    if (in_ready !== 4'b0010) begin errors++; $display("FAIL bp_release_ready got %b exp 0010", in_ready); end
    tick;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h22) begin
      errors++; $display("FAIL bp_release_out got v=%b d=%h exp v=1 d=22", out_valid, out_data);
    end
    in_valid = 4'b0000;
    tick;
  endtask

  task automatic test_non_pow2;
    logic [1:0] exp_g [4] = '{2'd0, 2'd1, 2'd2, 2'd0};
    m3 = 0; s3 = 3; v3 = 3'b111;
    #1;
    checks++;
    if (r3 !== 3'b000) begin errors++; $display("FAIL np2_sel3_ready got %b exp 000", r3); end
    tick;
    checks++;
    if (ov3 !== 1'b0) begin errors++; $display("FAIL np2_sel3_valid got %b exp 0", ov3); end
    m3 = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (r3 !== (3'b001 << exp_g[i])) begin
        errors++; $display("FAIL np2_rr_ready[%0d] got %b exp %b", i, r3, 3'b001 << exp_g[i]);
      end
      tick;
      checks++;
      if (ov3 !== 1'b1 || oc3 !== exp_g[i] || od3 !== 8'h11 * (8'(exp_g[i]) + 8'd1)) begin
        errors++; $display("FAIL np2_rr_out[%0d] got v=%b ch=%0d d=%h exp v=1 ch=%0d", i, ov3, oc3, od3, exp_g[i]);
      end
    end
    v3 = 3'b000;
  endtask

  task automatic test_reset_midstream;
    mode = 1; in_valid = 4'b1111; out_ready = 0; in_data = 32'h13121110;
    tick; tick;
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_loaded got v=%b exp 1", out_valid); end
    rst = 1; out_ready = 1;
    #1;
    checks++;
    if (in_ready !== 4'b0000) begin errors++; $display("FAIL mid_rst_ready got %b exp 0000", in_ready); end
    tick;
    rst = 0;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got %b exp 0", out_valid); end
    #1;
    checks++;
    if (in_ready !== 4'b0001) begin errors++; $display("FAIL mid_first_ready got %b exp 0001", in_ready); end
    tick;
    checks++;
    if (out_valid !== 1'b1 || out_ch !== 2'd0) begin
      errors++; $display("FAIL mid_first_out got v=%b ch=%0d exp v=1 ch=0", out_valid, out_ch);
    end
    in_valid = 4'b0000;
    tick;
  endtask

`ifdef STREAM_MUX_LOCK_EN
  task automatic test_lock;
    logic [1:0] exp_g [4] = '{2'd1, 2'd1, 2'd1, 2'd2};
    mode = 0; sel = 1; in_valid = 4'b0111; in_last = 4'b0000; out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      if (i == 1) mode = 1;
      in_last = (i == 2) ? 4'b0010 : 4'b0000;
      #1;
      checks++;
      if (in_ready !== (4'b0001 << exp_g[i])) begin
        errors++; $display("FAIL lock_ready[%0d] got %b exp %b", i, in_ready, 4'b0001 << exp_g[i]);
      end
      tick;
      checks++;
      if (out_valid !== 1'b1 || out_ch !== exp_g[i] || out_last !== (i == 2)) begin
        errors++; $display("FAIL lock_out[%0d] got v=%b ch=%0d last=%b exp v=1 ch=%0d last=%b",
                           i, out_valid, out_ch, out_last, exp_g[i], i == 2);
      end
    end
    in_valid = 4'b0000;
  endtask
`endif

  initial begin
    test_reset;
    test_rr_priority;
    test_fixed;
    test_backpressure;
    test_non_pow2;
    test_reset_midstream;
`ifdef STREAM_MUX_LOCK_EN
    test_lock;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
